// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-level debounce.
//
// Drives one active-low row at a time for SCAN_CMAX cycles. At the end of
// each dwell it samples the active-low columns into a 16-bit snapshot. Each
// full frame (four rows) is then classified as NONE, ONE(code) or MULTI. A
// press or release is accepted only after DEB_FRAMES consecutive agreeing
// frames.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   row_n     row drive, active-low, exactly one bit low
//   col_n     column sense, active-low, already synchronised to clk
//   key       code {row[1:0], col[1:0]} of the last accepted key
//   key_vld   one-cycle pulse when a new press is accepted
//   key_down  high while the accepted key is held
module keypad_scan #(
  parameter int SCAN_CMAX  = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] key,
  output logic       key_vld,
  output logic       key_down
);

  localparam int            CW         = (SCAN_CMAX > 1) ? $clog2(SCAN_CMAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_CMAX - 1);
  localparam logic [3:0]    DEB_LIMIT  = 4'(DEB_FRAMES);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } state_t;

  // Number of set bits in a 16-bit frame.
  function automatic logic [4:0] bit_count(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Index of the highest set bit. The caller only uses it when exactly one
  // bit is set, so that index is already the key code {row, col}.
  function automatic logic [3:0] bit_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  logic [CW-1:0] dwell;
  logic [1:0]    ptr;
  logic [1:0]    ptr_nxt;
  logic          tick;
  logic          frame_end;
  logic [15:0]   snap;
  logic [15:0]   frame;
  logic          is_one;
  logic [3:0]    one_code;
  logic          hit_cand;
  logic          hit_key;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cand;
  logic [3:0]    cand_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [3:0]    key_nxt;
  logic          down_nxt;
  logic          vld_nxt;

  assign tick      = (dwell == DWELL_LAST);
  assign frame_end = tick && (ptr == 2'd3);
  assign ptr_nxt   = ptr + 2'd1;

  // Row 3 is still being sampled on the frame-end edge, so it is taken from
  // the live columns rather than from the snapshot. Bit index = row*4 + col.
  assign frame    = {~col_n, snap[11:0]};
  assign is_one   = (bit_count(frame) == 5'd1);
  assign one_code = bit_index(frame);
  assign hit_cand = is_one && (one_code == cand);
  assign hit_key  = is_one && (one_code == key);

  // Scan stage: dwell counter, row pointer, row drive and snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
      ptr   <= 2'd0;
      row_n <= 4'b1110;
      snap  <= '0;
    end else begin
      dwell <= tick ? '0 : dwell + CW'(1);
      if (tick) begin
        snap[{ptr, 2'b00} +: 4] <= ~col_n;
        ptr                     <= ptr_nxt;
        row_n                   <= ~(4'b0001 << ptr_nxt);
      end
    end
  end

  // Debounce stage: FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      key      <= '0;
      key_down <= 1'b0;
      key_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      cnt      <= cnt_nxt;
      key      <= key_nxt;
      key_down <= down_nxt;
      key_vld  <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    key_nxt   = key;
    down_nxt  = key_down;
    vld_nxt   = 1'b0;

    if (frame_end) begin
      case (state)
        IDLE: begin
          if (is_one) begin
            state_nxt = PRESS_DEB;
            cand_nxt  = one_code;
            cnt_nxt   = 4'd1;
          end
        end

        PRESS_DEB: begin
          if (hit_cand) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == DEB_LIMIT) begin
              state_nxt = HELD;
              key_nxt   = cand;
              down_nxt  = 1'b1;
              vld_nxt   = 1'b1;
              cnt_nxt   = '0;
            end
          end else if (is_one) begin
            // A different single key restarts debounce on the new candidate.
            cand_nxt = one_code;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end

        HELD: begin
          if (!hit_key) begin
            state_nxt = RELEASE_DEB;
            cnt_nxt   = 4'd1;
          end
        end

        RELEASE_DEB: begin
          if (hit_key) begin
            // Key seen again: a release glitch, not a new press.
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt + 4'd1 == DEB_LIMIT) begin
            state_nxt = IDLE;
            down_nxt  = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: table-driven plus randomized bench for keypad_scan.
// The keypad matrix is modelled as col_n[c]=0 iff row_n[r]=0 and key (r,c)
// is pressed. A frame-level reference model predicts every output each cycle.
module tb_keypad_scan;

  localparam int SC  = 4;
  localparam int DEB = 3;
  localparam int FR  = 4 * SC;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key;
  logic        key_vld;
  logic        key_down;
  logic [15:0] pressed;

  keypad_scan #(.SCAN_CMAX(SC), .DEB_FRAMES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key      (key),
    .key_vld  (key_vld),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
      end
    end
  end

  // Reference model state: cycle position in frame, sampled matrix, runs of
  // agreeing frames toward a press or a release.
  int          m_t;
  logic [15:0] m_snap;
  int          m_press_run;
  int          m_press_k;
  int          m_rel_run;
  logic        m_down;
  logic        m_vld;
  logic [3:0]  m_key;

  int n_vec;
  int n_err;
  int vld_seen;
  int vld_first;
  int step_cyc;

  typedef struct {
    logic [15:0] mask;
    int          frames;
    bit          do_rst;
    int          exp_vld_cnt;
    int          exp_vld_at;
    logic [3:0]  exp_key;
    bit          exp_down;
  } vec_t;

  vec_t tbl[18];

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_frame();
    int nbits;
    int idx;
    nbits = 0;
    idx   = -1;
    for (int i = 0; i < 16; i++) begin
      if (m_snap[i]) begin
        nbits++;
        idx = i;
      end
    end
    if (!m_down) begin
      if (nbits == 1) begin
        m_press_run = (m_press_run > 0 && idx == m_press_k) ? m_press_run + 1 : 1;
        m_press_k   = idx;
        if (m_press_run == DEB) begin
          m_down      = 1'b1;
          m_key       = idx[3:0];
          m_vld       = 1'b1;
          m_press_run = 0;
          m_rel_run   = 0;
        end
      end else begin
        m_press_run = 0;
      end
    end else begin
      if (nbits == 1 && idx == int'(m_key)) begin
        m_rel_run = 0;
      end else begin
        m_rel_run++;
        if (m_rel_run == DEB) begin
          m_down      = 1'b0;
          m_rel_run   = 0;
          m_press_run = 0;
        end
      end
    end
  endtask

  // Predicts the outputs after the coming posedge from the current inputs.
  task automatic model_step();
    int row;
    if (rst) begin
      m_t = 0; m_snap = '0; m_press_run = 0; m_press_k = 0; m_rel_run = 0;
      m_down = 1'b0; m_vld = 1'b0; m_key = '0;
      return;
    end
    m_vld = 1'b0;
    row   = (m_t / SC) % 4;
    if (m_t % SC == SC - 1) begin
      for (int c = 0; c < 4; c++) m_snap[row*4+c] = pressed[row*4+c];
      if (row == 3) model_frame();
    end
    m_t = (m_t + 1) % FR;
  endtask

  task automatic cyc();
    logic [3:0] one_hot;
    logic [3:0] exp_row;
    model_step();
    @(posedge clk);
    @(negedge clk);
    one_hot = 4'b0001;
    exp_row = ~(one_hot << ((m_t / SC) % 4));
    chk4("row_n", row_n, exp_row);
    chk4("key", key, m_key);
    chk4("key_vld", {3'b000, key_vld}, {3'b000, m_vld});
    chk4("key_down", {3'b000, key_down}, {3'b000, m_down});
    if (key_vld) begin
      vld_seen++;
      if (vld_first < 0) vld_first = step_cyc;
    end
    step_cyc++;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    pressed = v.mask;
    if (v.do_rst) reset_cycle();
    step_cyc  = 0;
    vld_seen  = 0;
    vld_first = -1;
    repeat (v.frames * FR) cyc();
    chk_int($sformatf("vec%0d_vld_count", idx), vld_seen, v.exp_vld_cnt);
    chk_int($sformatf("vec%0d_vld_cycle", idx), vld_first, v.exp_vld_at);
    chk4($sformatf("vec%0d_key", idx), key, v.exp_key);
    chk4($sformatf("vec%0d_key_down", idx), {3'b000, key_down}, {3'b000, v.exp_down});
  endtask

  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K10 = 16'h0400;
  localparam logic [15:0] K15 = 16'h8000;

  initial begin
    n_vec = 0; n_err = 0; vld_seen = 0; vld_first = -1; step_cyc = 0;
    rst = 1'b1; pressed = '0;
    m_t = 0; m_snap = '0; m_press_run = 0; m_press_k = 0; m_rel_run = 0;
    m_down = 1'b0; m_vld = 1'b0; m_key = '0;

    //            mask       fr rst vcnt vat key  down
    tbl[0]  = '{16'h0000,   2, 1, 0, -1, 4'd0, 0};
    tbl[1]  = '{K6,         1, 0, 0, -1, 4'd0, 0};
    tbl[2]  = '{16'h0000,   1, 0, 0, -1, 4'd0, 0};
    tbl[3]  = '{K6,         1, 0, 0, -1, 4'd0, 0};
    tbl[4]  = '{16'h0000,   1, 0, 0, -1, 4'd0, 0};
    tbl[5]  = '{K6,         1, 0, 0, -1, 4'd0, 0};
    tbl[6]  = '{16'h0000,   1, 0, 0, -1, 4'd0, 0};
    tbl[7]  = '{K6,         1, 0, 0, -1, 4'd0, 0};
    tbl[8]  = '{16'h0000,   1, 0, 0, -1, 4'd0, 0};
    tbl[9]  = '{K5 | K10,   5, 0, 0, -1, 4'd0, 0};
    tbl[10] = '{K5,         3, 0, 1, 47, 4'd5, 1};
    tbl[11] = '{16'h0000,   3, 0, 0, -1, 4'd5, 0};
    tbl[12] = '{K6,         6, 0, 1, 47, 4'd6, 1};
    tbl[13] = '{16'h0000,   1, 0, 0, -1, 4'd6, 1};
    tbl[14] = '{K6,         1, 0, 0, -1, 4'd6, 1};
    tbl[15] = '{16'h0000,   3, 0, 0, -1, 4'd6, 0};
    tbl[16] = '{K15,        2, 0, 0, -1, 4'd6, 0};
    tbl[17] = '{16'h0000,   1, 1, 0, -1, 4'd0, 0};

    for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

    // Reset lands exactly on the edge that would have accepted key 9.
    pressed = K9;
    reset_cycle();
    repeat (3 * FR - 1) cyc();
    reset_cycle();
    chk4("midreset_row_n", row_n, 4'b1110);
    chk4("midreset_key_vld", {3'b000, key_vld}, 4'd0);
    chk4("midreset_key_down", {3'b000, key_down}, 4'd0);
    chk4("midreset_key", key, 4'd0);
    step_cyc = 0; vld_seen = 0; vld_first = -1;
    repeat (3 * FR) cyc();
    chk_int("after_reset_vld_cycle", vld_first, 47);
    chk4("after_reset_key", key, 4'd9);

    // Randomized key activity, changing at arbitrary points inside frames.
    for (int n = 0; n < 80; n++) begin
      int kind;
      int len;
      logic [15:0] m;
      kind = int'($urandom_range(0, 11));
      m    = '0;
      if (kind == 0) begin
        reset_cycle();
      end else if (kind >= 3 && kind <= 8) begin
        m[$urandom_range(0, 15)] = 1'b1;
      end else if (kind >= 9) begin
        m[$urandom_range(0, 15)] = 1'b1;
        m[$urandom_range(0, 15)] = 1'b1;
      end
      pressed = m;
      len = int'($urandom_range(1, 5 * FR));
      repeat (len) cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
